add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 10, operand/sum width; must be a multiple of 2, otherwise elaboration error.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  NUM_REQ  per-requester request level.
REQ-006 SHALL have port a_i  input  NUM_REQ*WIDTH  packed operand A; slice k belongs to requester k.
REQ-007 SHALL have port b_i  input  NUM_REQ*WIDTH  packed operand B, same packing.
REQ-008 SHALL have port gnt_o  output  NUM_REQ  one-hot grant pulse, registered.
REQ-009 SHALL have port done_o  output  NUM_REQ  one-hot completion pulse, registered.
REQ-010 SHALL have port id_o  output  clog2(NUM_REQ)  index of requester owning sum_o.
REQ-011 SHALL have port sum_o  output  WIDTH  result of last completed add.
REQ-012 SHALL have port busy_o  output  1  high while an add is in flight.

Function
REQ-013 SHALL implement states IDLE and ADD only.
REQ-014 In IDLE, at an edge where req_i is nonzero, SHALL pick a winner round-robin starting at pointer ptr, latch its A/B slices, set gnt_o one-hot for exactly one cycle, set busy_o, clear digit counter and carry, enter ADD.
REQ-015 In ADD, SHALL process 2 bits per cycle LSB-first via one shared 2-bit ripple stage with registered inter-digit carry; WIDTH/2 cycles (5 at default).
REQ-016 At the edge completing the last digit, SHALL update sum_o and id_o, pulse done_o one-hot for one cycle, clear busy_o, set ptr to winner+1 mod NUM_REQ, return to IDLE.
REQ-017 Latency: grant edge E0; done_o/sum_o visible in cycle after edge E(WIDTH/2); next grant earliest at edge E(WIDTH/2+1); throughput one add per WIDTH/2+1 cycles.
REQ-018 sum_o SHALL equal (A+B) mod 2^WIDTH and hold until next completion.
REQ-019 req_i SHALL be ignored outside IDLE; operands captured at grant, later a_i/b_i changes have no effect.
REQ-020 A requester still holding req_i at the next IDLE edge after its done_o SHALL be treated as a new request (requester drops req_i on gnt_o).
REQ-021 Winner's own request asserted in the done_o cycle SHALL rank lowest due to pointer advance.

Reset
REQ-022 rst high at an edge SHALL force IDLE, ptr=0, gnt_o=0, done_o=0, id_o=0, sum_o=0, busy_o=0, carry=0, overriding all other activity.
REQ-023 Reset mid-ADD SHALL discard the operation; no done_o for it.

Configuration
REQ-024 With macro ADD_ARB_CARRY_EN defined, SHALL add port cout_o output 1, carry out of MSB, updated with sum_o, reset 0.
REQ-025 Without ADD_ARB_CARRY_EN, SHALL have no cout_o port and discard the final carry.

Structure
REQ-026 Package add_arb_pkg SHALL hold the state enum, DIGIT_BITS=2 and the derived digit-count function.
REQ-027 Digit datapath (2-bit add, carry flop, sum shift register) SHALL be sub-module serial_add_core; arbitration and sequencing stay in add_arbiter.

Verification
REQ-028 Single req: req_i=0001, A0=300, B0=200 -> gnt_o=0001 after E0; done_o=0001 after E5; sum_o=500, id_o=0.
REQ-029 Inter-digit carry: A=255, B=1 -> sum_o=256; A=341, B=341 -> sum_o=682.
REQ-030 Overflow: A=1023, B=1 -> sum_o=0; cout_o=1 with ADD_ARB_CARRY_EN.
REQ-031 Contention: req_i=1111 from reset, each drops on grant -> grants 0,1,2,3, spaced 6 cycles, correct per-requester sums.
REQ-032 Fairness: req0, req2 held high continuously -> grants alternate 0,2,0,2.
REQ-033 Reset in digit 3 -> busy_o=0 next cycle, no done_o; subsequent req_i=0100 served normally from ptr=0.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared types and digit-serial sizing for the round-robin serial adder arbiter.
package add_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ADD  = 1'b1
   } state_t;

   localparam int DIGIT_BITS = 2;

   function automatic int num_digits(input int width);
      return width / DIGIT_BITS;
   endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Request/operand/result bundle for add_arbiter.
// Optional ADD_ARB_CARRY_EN adds the cout_o carry-out signal.
interface add_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 10
) ();
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_i;
   logic [NUM_REQ*WIDTH-1:0] a_i;
   logic [NUM_REQ*WIDTH-1:0] b_i;
   logic [NUM_REQ-1:0]       gnt_o;
   logic [NUM_REQ-1:0]       done_o;
   logic [IDW-1:0]           id_o;
   logic [WIDTH-1:0]         sum_o;
   logic                     busy_o;
`ifdef ADD_ARB_CARRY_EN
   logic                     cout_o;
`endif

   modport slave (
      input  req_i, a_i, b_i,
      output gnt_o, done_o, id_o, sum_o,
`ifdef ADD_ARB_CARRY_EN
      cout_o,
`endif
      busy_o
   );

   modport master (
      output req_i, a_i, b_i,
      input  gnt_o, done_o, id_o, sum_o,
`ifdef ADD_ARB_CARRY_EN
      cout_o,
`endif
      busy_o
   );
endinterface

// File: rtl/add_arbiter_serial_add_core.sv
// Digit-serial adder: one shared 2-bit ripple stage, registered carry, sum shift register.
// ADD_ARB_CARRY_EN exposes the next carry so the top can register the final carry-out.
module serial_add_core
   import add_arb_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
`ifdef ADD_ARB_CARRY_EN
   output logic             o_cout_nxt,
`endif
   output logic [WIDTH-1:0] o_sum_nxt
);
   logic [WIDTH-1:0]      r_a;
   logic [WIDTH-1:0]      r_b;
   logic [WIDTH-1:0]      r_sum;
   logic                  r_carry;
   logic [DIGIT_BITS:0]   w_dig;

   assign w_dig = {1'b0, r_a[DIGIT_BITS-1:0]} + {1'b0, r_b[DIGIT_BITS-1:0]}
                + {{DIGIT_BITS{1'b0}}, r_carry};

   // new digit enters at the MSB end so the word is aligned after the last step
   if (WIDTH > DIGIT_BITS) begin : g_shift
      assign o_sum_nxt = {w_dig[DIGIT_BITS-1:0], r_sum[WIDTH-1:DIGIT_BITS]};
   end else begin : g_single
      assign o_sum_nxt = w_dig[DIGIT_BITS-1:0];
   end

`ifdef ADD_ARB_CARRY_EN
   assign o_cout_nxt = w_dig[DIGIT_BITS];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else if (i_load) begin
         r_a     <= i_a;
         r_b     <= i_b;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else if (i_step) begin
         r_a     <= r_a >> DIGIT_BITS;
         r_b     <= r_b >> DIGIT_BITS;
         r_sum   <= o_sum_nxt;
         r_carry <= w_dig[DIGIT_BITS];
      end
   end
endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding a shared digit-serial adder; one add in flight at a time.
// ADD_ARB_CARRY_EN adds a registered carry-out of the MSB (cout_o).
//
// state   | meaning
// IDLE    | waiting for any request; grants round-robin from r_ptr
// ADD     | winner's operands being added 2 bits per cycle
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 10
) (
   input  logic          clk,
   input  logic          rst,
   add_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int ND  = num_digits(WIDTH);
   localparam int CW  = (ND > 1) ? $clog2(ND) : 1;

   if ((WIDTH % DIGIT_BITS) != 0) begin : g_bad_width
      $error("add_arbiter: WIDTH must be a multiple of 2");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("add_arbiter: NUM_REQ must be in 2..8");
   end

   state_t             r_state, w_state_nxt;
   logic [IDW-1:0]     r_ptr, w_ptr_nxt;
   logic [IDW-1:0]     r_win, w_win_nxt;
   logic [CW-1:0]      r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
   logic [NUM_REQ-1:0] r_done, w_done_nxt;
   logic [IDW-1:0]     r_id, w_id_nxt;
   logic [WIDTH-1:0]   r_sum, w_sum_nxt;
   logic               r_busy, w_busy_nxt;
   logic               w_load, w_step;
   logic               w_req_any;
   logic [IDW-1:0]     w_win_idx;
   logic [IDW-1:0]     w_probe;
   logic [WIDTH-1:0]   w_a_sel, w_b_sel;
   logic [WIDTH-1:0]   w_core_sum;
`ifdef ADD_ARB_CARRY_EN
   logic               r_cout, w_cout_nxt, w_core_cout;
`endif

   // scan from the far end so the hit closest to r_ptr wins
   always_comb begin
      w_req_any = 1'b0;
      w_win_idx = '0;
      w_probe   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_probe = IDW'((int'(r_ptr) + i) % NUM_REQ);
         if (bus.req_i[w_probe]) begin
            w_req_any = 1'b1;
            w_win_idx = w_probe;
         end
      end
   end

   assign w_a_sel = bus.a_i[int'(w_win_idx)*WIDTH +: WIDTH];
   assign w_b_sel = bus.b_i[int'(w_win_idx)*WIDTH +: WIDTH];

   serial_add_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_a        (w_a_sel),
      .i_b        (w_b_sel),
`ifdef ADD_ARB_CARRY_EN
      .o_cout_nxt (w_core_cout),
`endif
      .o_sum_nxt  (w_core_sum)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_win_nxt   = r_win;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = '0;
      w_done_nxt  = '0;
      w_id_nxt    = r_id;
      w_sum_nxt   = r_sum;
      w_busy_nxt  = r_busy;
      w_load      = 1'b0;
      w_step      = 1'b0;
`ifdef ADD_ARB_CARRY_EN
      w_cout_nxt  = r_cout;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_load               = 1'b1;
               w_gnt_nxt[w_win_idx] = 1'b1;
               w_win_nxt            = w_win_idx;
               w_busy_nxt           = 1'b1;
               w_cnt_nxt            = CW'(ND - 1);
               w_state_nxt          = ST_ADD;
            end
         end
         ST_ADD: begin
            w_step = 1'b1;
            if (r_cnt == '0) begin
               w_sum_nxt        = w_core_sum;
               w_id_nxt         = r_win;
               w_done_nxt[r_win] = 1'b1;
               w_busy_nxt       = 1'b0;
               w_ptr_nxt        = (r_win == IDW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
               w_state_nxt      = ST_IDLE;
`ifdef ADD_ARB_CARRY_EN
               w_cout_nxt       = w_core_cout;
`endif
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_id    <= '0;
         r_sum   <= '0;
         r_busy  <= 1'b0;
`ifdef ADD_ARB_CARRY_EN
         r_cout  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_win   <= w_win_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
         r_id    <= w_id_nxt;
         r_sum   <= w_sum_nxt;
         r_busy  <= w_busy_nxt;
`ifdef ADD_ARB_CARRY_EN
         r_cout  <= w_cout_nxt;
`endif
      end
   end

   assign bus.gnt_o  = r_gnt;
   assign bus.done_o = r_done;
   assign bus.id_o   = r_id;
   assign bus.sum_o  = r_sum;
   assign bus.busy_o = r_busy;
`ifdef ADD_ARB_CARRY_EN
   assign bus.cout_o = r_cout;
`endif
endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: expected grants/results queued at stimulus time.
module tb_add_arbiter;
   localparam int NR = 4;
   localparam int W  = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) u_if ();
   add_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(u_if));

   typedef struct {
      int id;
      int sum;
      int cout;
   } exp_t;

   exp_t          exp_q[$];
   int            gnt_q[$];
   int            n_chk = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            last_gnt = 0;
   bit            gap_mode = 1'b0;
   bit            have_prev = 1'b0;
   logic [NR-1:0] hold = '0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_op(input int k, input int a, input int b);
      u_if.a_i[k*W +: W] = W'(a);
      u_if.b_i[k*W +: W] = W'(b);
   endtask

   task automatic expect_add(input int k, input int a, input int b);
      exp_t e;
      e.id   = k;
      e.sum  = (a + b) % (1 << W);
      e.cout = (a + b) / (1 << W);
      gnt_q.push_back(k);
      exp_q.push_back(e);
      set_op(k, a, b);
   endtask

   task automatic tick();
      exp_t e;
      int   k;
      @(posedge clk);
      #1;
      cyc++;
      if (u_if.gnt_o != '0) begin
         if (gnt_q.size() == 0) begin
            check_val("gnt_unexp", 32'(u_if.gnt_o), 0);
         end else begin
            k = gnt_q.pop_front();
            check_val("gnt", 32'(u_if.gnt_o), 32'(1) << k);
            check_val("busy_at_gnt", 32'(u_if.busy_o), 1);
            if (gap_mode && have_prev) check_val("gnt_gap", cyc - last_gnt, 6);
            have_prev = 1'b1;
            last_gnt  = cyc;
            for (int i = 0; i < NR; i++)
               if (u_if.gnt_o[i] && !hold[i]) u_if.req_i[i] = 1'b0;
            if (gnt_q.size() == 0) begin
               u_if.req_i = '0;
               hold       = '0;
            end
         end
      end
      if (u_if.done_o != '0) begin
         if (exp_q.size() == 0) begin
            check_val("done_unexp", 32'(u_if.done_o), 0);
         end else begin
            e = exp_q.pop_front();
            check_val("done", 32'(u_if.done_o), 32'(1) << e.id);
            check_val("id", 32'(u_if.id_o), e.id);
            check_val("sum", 32'(u_if.sum_o), e.sum);
            check_val("busy_at_done", 32'(u_if.busy_o), 0);
            check_val("latency", cyc - last_gnt, 5);
`ifdef ADD_ARB_CARRY_EN
            check_val("cout", 32'(u_if.cout_o), e.cout);
`endif
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0 || gnt_q.size() != 0) begin
         check_val("drain_timeout", exp_q.size() + gnt_q.size(), 0);
         exp_q.delete();
         gnt_q.delete();
         u_if.req_i = '0;
      end
      tick();
   endtask

   task automatic wait_gnt(input int budget);
      int n;
      int target;
      n = 0;
      target = exp_q.size();
      while (gnt_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (gnt_q.size() != 0) check_val("gnt_timeout", gnt_q.size(), 0);
      check_val("pending_after_gnt", exp_q.size(), target);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      have_prev = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      u_if.req_i = '0;
      u_if.a_i   = '0;
      u_if.b_i   = '0;
      do_reset();
      check_val("rst_gnt", 32'(u_if.gnt_o), 0);
      check_val("rst_done", 32'(u_if.done_o), 0);
      check_val("rst_id", 32'(u_if.id_o), 0);
      check_val("rst_sum", 32'(u_if.sum_o), 0);
      check_val("rst_busy", 32'(u_if.busy_o), 0);
`ifdef ADD_ARB_CARRY_EN
      check_val("rst_cout", 32'(u_if.cout_o), 0);
`endif

      // single requester and inter-digit carries
      expect_add(0, 300, 200);  u_if.req_i = 4'b0001; drain(40);
      expect_add(0, 255, 1);    u_if.req_i = 4'b0001; drain(40);
      expect_add(1, 341, 341);  u_if.req_i = 4'b0010; drain(40);

      // overflow, with operands scrambled after grant
      expect_add(3, 1023, 1);   u_if.req_i = 4'b1000;
      wait_gnt(10);
      set_op(3, 5, 9);
      drain(40);

      // contention: all four from reset, each drops on grant
      do_reset();
      gap_mode = 1'b1;
      expect_add(0, 10, 20);
      expect_add(1, 512, 511);
      expect_add(2, 700, 400);
      expect_add(3, 85, 170);
      u_if.req_i = 4'b1111;
      drain(80);

      // fairness: req0 and req2 held
      do_reset();
      hold = 4'b0101;
      expect_add(0, 1, 2);
      expect_add(2, 600, 3);
      expect_add(0, 1, 2);
      expect_add(2, 600, 3);
      u_if.req_i = 4'b0101;
      drain(80);
      gap_mode = 1'b0;

      // reset during digit 3 after moving the pointer away from 0
      expect_add(1, 7, 8);      u_if.req_i = 4'b0010; drain(40);
      expect_add(3, 100, 200);  u_if.req_i = 4'b1000;
      wait_gnt(10);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check_val("rst_mid_busy", 32'(u_if.busy_o), 0);
      check_val("rst_mid_done", 32'(u_if.done_o), 0);
      rst = 1'b0;
      exp_q.delete();
      have_prev = 1'b0;
      repeat (10) tick();
      check_val("rst_mid_sum", 32'(u_if.sum_o), 0);

      expect_add(0, 11, 22);
      expect_add(2, 33, 44);
      u_if.req_i = 4'b0101;
      drain(40);
      expect_add(2, 1000, 23);  u_if.req_i = 4'b0100; drain(40);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
